// File: rtl/predictor_pkg.sv
// Shared defaults and helpers for the correlated (gshare-style) branch predictor.
package predictor_pkg;

  localparam int DEF_HIST_BITS = 2;
  localparam int DEF_IDX_BITS  = 6;
  localparam int DEF_CNT_BITS  = 2;
  localparam int MISP_CNT_W    = 16;

  // Weakly-not-taken is the largest value whose MSB is still clear.
  function automatic logic [3:0] weakNotTaken(input int cntBits);
    return 4'((1 << (cntBits - 1)) - 1);
  endfunction

endpackage

// File: rtl/sat_counter_nbit.sv
// Saturating up/down counter step: returns i_cnt moved one step toward i_inc's direction.
module sat_counter_nbit #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_cnt,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_inc) begin
      if (i_cnt != '1) o_cnt = i_cnt + 1'b1;
    end else begin
      if (i_cnt != '0) o_cnt = i_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/predictor_correlated_param.sv
// Global-history correlated predictor: PC xor GHR indexes a table of saturating counters,
// with same-cycle update bypass, speculative history shift and mispredict repair.
module predictor_correlated_param
  import predictor_pkg::*;
#(
  parameter int HIST_BITS = DEF_HIST_BITS,
  parameter int IDX_BITS  = DEF_IDX_BITS,
  parameter int CNT_BITS  = DEF_CNT_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  predict_taken,
  output logic [HIST_BITS-1:0]  lookup_hist,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic [HIST_BITS-1:0]  upd_hist,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [MISP_CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] WEAK_NT = CNT_BITS'(weakNotTaken(CNT_BITS));

  logic [CNT_BITS-1:0]   r_table [ENTRIES];
  logic [HIST_BITS-1:0]  r_ghr;
  logic [MISP_CNT_W-1:0] r_mispCount;
  logic                  r_firstCycle;

  logic [IDX_BITS-1:0]   w_lookupIdx;
  logic [IDX_BITS-1:0]   w_updIdx;
  logic [CNT_BITS-1:0]   w_updNext;
  logic [CNT_BITS-1:0]   w_lookupCnt;
  logic                  w_repair;
  logic [HIST_BITS-1:0]  w_specHist;
  logic [HIST_BITS-1:0]  w_repairHist;
  logic                  w_unusedPcBits;

  assign w_lookupIdx = lookup_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
  assign w_updIdx    = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_hist);
  assign w_repair    = upd_valid & upd_mispredict;

  assign w_unusedPcBits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  // The single counter step feeds both the table write and the same-cycle bypass.
  sat_counter_nbit #(.W(CNT_BITS)) u_satCounter (
    .i_cnt (r_table[w_updIdx]),
    .i_inc (upd_taken),
    .o_cnt (w_updNext)
  );

  assign w_lookupCnt = (upd_valid && (w_updIdx == w_lookupIdx)) ? w_updNext
                                                                 : r_table[w_lookupIdx];

  assign predict_taken    = lookup_valid & reset & ~r_firstCycle & w_lookupCnt[CNT_BITS-1];
  assign lookup_hist      = r_ghr;
  assign mispredict_count = r_mispCount;

  if (HIST_BITS == 1) begin : g_hist1
    assign w_specHist   = predict_taken;
    assign w_repairHist = upd_taken;
  end else begin : g_histN
    assign w_specHist   = {r_ghr[HIST_BITS-2:0], predict_taken};
    assign w_repairHist = {upd_hist[HIST_BITS-2:0], upd_taken};
  end

  // Repair wins over the speculative shift: the younger D-stage branch is being flushed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ghr        <= '0;
      r_mispCount  <= '0;
      r_firstCycle <= 1'b1;
    end else begin
      r_firstCycle <= 1'b0;
      if (w_repair) begin
        r_ghr <= w_repairHist;
      end else if (lookup_valid) begin
        r_ghr <= w_specHist;
      end
      if (w_repair && (r_mispCount != '1)) begin
        r_mispCount <= r_mispCount + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= WEAK_NT;
      end
    end else if (upd_valid) begin
      r_table[w_updIdx] <= w_updNext;
    end
  end

endmodule

// File: tb/tb_predictor_correlated_param.sv
// Directed bench for predictor_correlated_param at default parameters (2-bit GHR, 64 entries, 2-bit counters).
module tb_predictor_correlated_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [1:0]  lookup_hist;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_hist;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [15:0] mispredict_count;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clock = ~clock;

  predictor_correlated_param dut (
    .clock            (clock),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .lookup_hist      (lookup_hist),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_hist         (upd_hist),
    .upd_taken        (upd_taken),
    .upd_mispredict   (upd_mispredict),
    .mispredict_count (mispredict_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [31:0] lpc, input logic uv,
                               input logic [31:0] upc, input logic [1:0] uh,
                               input logic ut, input logic um);
    lookup_valid   = lv;
    lookup_pc      = lpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_hist       = uh;
    upd_taken      = ut;
    upd_mispredict = um;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a lookup only long enough to observe it, so the GHR does not shift.
  task automatic peekCheck(input string tag, input logic [31:0] pc, input logic expPred);
    applyStimulus(1'b1, pc, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput(tag, 32'(predict_taken), 32'(expPred));
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();

    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("predInReset", 32'(predict_taken), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstPred", 32'(predict_taken), 32'd0);
    checkOutput("rstHist", 32'(lookup_hist), 32'd0);
    checkOutput("rstCount", 32'(mispredict_count), 32'd0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("rstPredAnyPc", 32'(predict_taken), 32'd0);
    idle();
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 2'b00, 1'b1, 1'b0);
      tick();
      idle();
      if (i == 0) peekCheck("firstTakenUpd", 32'h40, 1'b1);
    end
    peekCheck("satTaken", 32'h40, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 2'b00, 1'b0, 1'b0);
    tick();
    peekCheck("satThenDec1", 32'h40, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 2'b00, 1'b0, 1'b0);
    tick();
    peekCheck("satThenDec2", 32'h40, 1'b0);

    // Counter at idx 0x10 is now 01; a taken update in the same cycle must bypass.
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h40, 2'b00, 1'b1, 1'b0);
    #1;
    checkOutput("bypassPred", 32'(predict_taken), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 2'b00, 1'b1, 1'b0);
    tick();
    idle();

    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("shiftPred", 32'(predict_taken), 32'd1);
    tick();
    idle();
    #1;
    checkOutput("ghrAfterShift", 32'(lookup_hist), 32'h1);
    applyStimulus(1'b1, 32'h44, 1'b1, 32'h80, 2'b10, 1'b0, 1'b1);
    #1;
    checkOutput("predBeforeRepair", 32'(predict_taken), 32'd1);
    tick();
    idle();
    #1;
    checkOutput("repairWins", 32'(lookup_hist), 32'h0);
    checkOutput("countAfterRepair", 32'(mispredict_count), 32'd1);

    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("specPred1", 32'(predict_taken), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("specPred2", 32'(predict_taken), 32'd1);
    tick();
    idle();
    #1;
    checkOutput("ghrTwoTaken", 32'(lookup_hist), 32'h3);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 2'b11, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("ghrCorrectUpd", 32'(lookup_hist), 32'h3);
    tick();
    checkOutput("ghrStill11", 32'(lookup_hist), 32'h3);

    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("mispIgnoredCount", 32'(mispredict_count), 32'd1);
    checkOutput("mispIgnoredHist", 32'(lookup_hist), 32'h3);

    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 65533; i++) tick();
    checkOutput("countNearSat", 32'(mispredict_count), 32'hFFFE);
    for (int i = 0; i < 4467; i++) tick();
    checkOutput("countSat", 32'(mispredict_count), 32'hFFFF);
    checkOutput("ghrRepaired", 32'(lookup_hist), 32'h0);

    // Reset for one edge while an update and a lookup are being presented.
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, 2'b00, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("predInMidReset", 32'(predict_taken), 32'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("midRstPred", 32'(predict_taken), 32'd0);
    checkOutput("midRstCount", 32'(mispredict_count), 32'd0);
    checkOutput("midRstHist", 32'(lookup_hist), 32'h0);
    idle();
    tick();
    peekCheck("midRstTable10", 32'h40, 1'b0);
    peekCheck("midRstTable03", 32'h0C, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 2'b00, 1'b1, 1'b0);
    tick();
    peekCheck("midRstTable00", 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/predictor_correlated_param.md
PREDICTOR_CORRELATED_PARAM -- requirements
Module: predictor_correlated_param

Interface
REQ-001 The module SHALL have parameter HIST_BITS, default 2; global branch history length, range 1..IDX_BITS.
REQ-002 The module SHALL have parameter IDX_BITS, default 6; pattern table index width, giving 2^IDX_BITS entries.
REQ-003 The module SHALL have parameter CNT_BITS, default 2; saturating counter width, range 2..4.
REQ-004 The module SHALL have port clock, input, 1 bit; the single clock, rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit; synchronous, active-low reset.
REQ-006 The module SHALL have port lookup_valid, input, 1 bit; a branch is in D this cycle.
REQ-007 The module SHALL have port lookup_pc, input, 32 bits; PC of the D-stage branch.
REQ-008 The module SHALL have port predict_taken, output, 1 bit; predicted direction, combinational from the current state.
REQ-009 The module SHALL have port lookup_hist, output, HIST_BITS bits; GHR value used for this lookup, carried down the pipe by the caller.
REQ-010 The module SHALL have port upd_valid, input, 1 bit; a branch resolved in X this cycle.
REQ-011 The module SHALL have port upd_pc, input, 32 bits; PC of the resolved branch.
REQ-012 The module SHALL have port upd_hist, input, HIST_BITS bits; lookup_hist captured when the resolved branch was predicted.
REQ-013 The module SHALL have port upd_taken, input, 1 bit; actual branch outcome.
REQ-014 The module SHALL have port upd_mispredict, input, 1 bit; resolved direction differed from prediction.
REQ-015 The module SHALL have port mispredict_count, output, 16 bits; saturating count of upd_mispredict events.

Function
REQ-016 idx(pc,h) SHALL be pc[IDX_BITS+1:2] XOR h, with h zero-extended to IDX_BITS.
REQ-017 predict_taken SHALL equal the MSB of counter[idx(lookup_pc, GHR)], and lookup_hist SHALL equal GHR; predict_taken SHALL be 0 when lookup_valid=0.
REQ-018 When upd_valid=1, counter[idx(upd_pc,upd_hist)] SHALL increment if upd_taken=1 and decrement otherwise, saturating at 0 and 2^CNT_BITS-1, written at the next edge.
REQ-019 Bypass: when the upd_valid and lookup indices match in the same cycle, predict_taken SHALL use the post-update counter value.
REQ-020 Speculative history: when lookup_valid=1 and no mispredict is signalled, GHR SHALL load {GHR[HIST_BITS-2:0], predict_taken} at the next edge.
REQ-021 Repair: when upd_valid=1 and upd_mispredict=1, GHR SHALL load {upd_hist[HIST_BITS-2:0], upd_taken}.
REQ-022 Repair SHALL override a same-cycle lookup shift, because the younger D branch is flushed.
REQ-023 When upd_valid=1 and upd_mispredict=0, GHR SHALL be left unchanged by the update.
REQ-024 For HIST_BITS=1, the shift SHALL reduce to loading the single new bit.
REQ-025 mispredict_count SHALL increment on each upd_valid & upd_mispredict and hold at 16'hFFFF.
REQ-026 upd_mispredict SHALL be ignored when upd_valid=0.

Reset
REQ-027 While reset=0 at a rising edge, GHR SHALL become 0, mispredict_count SHALL become 0, and every counter SHALL become weakly-not-taken (2^(CNT_BITS-1)-1).
REQ-028 Any update or lookup presented in a reset cycle SHALL be discarded.
REQ-029 predict_taken SHALL be 0 during reset and in the first cycle after reset.

Structure
REQ-030 Package predictor_pkg SHALL hold the default HIST_BITS/IDX_BITS/CNT_BITS values, the weak-not-taken function of CNT_BITS, and the mispredict counter width.
REQ-031 One sub-module, sat_counter_nbit (CNT_BITS-wide increment/decrement with saturation), SHALL be used for the update path and the bypass path.
REQ-032 The table SHALL be a flat register array with no RAM macro; reset clears every entry.

Verification
REQ-033 The bench SHALL check: after reset, lookup at any PC -> predict_taken=0 and lookup_hist=0.
REQ-034 The bench SHALL check: four taken updates at PC 0x40 with hist 0 -> counter saturates at 3, and a fifth update leaves it at 3.
REQ-035 The bench SHALL check: lookup and update at the same index in the same cycle, counter 01 with upd_taken=1 -> predict_taken=1 via the bypass.
REQ-036 The bench SHALL check: GHR=2'b01, lookup predicting 1, and a simultaneous mispredict with upd_hist=2'b10, upd_taken=0 -> GHR=2'b00 next cycle.
REQ-037 The bench SHALL check: two lookups predicting taken, then an update with upd_mispredict=0 -> GHR=2'b11 and remains 2'b11.
REQ-038 The bench SHALL check: 70000 mispredict updates -> mispredict_count=16'hFFFF, and reset low for one edge mid-stream -> all state at reset values.
